// File: rtl/decoder_addr_sequencer.sv
// decoder_addr_sequencer: FIFO-buffered select issue and 0..3 scan for a 2-to-4 enable decoder (optional SEQ_OVERFLOW_FLAG_EN adds a sticky overflow port)
module decoder_addr_sequencer #(
  parameter int DEPTH   = 4,
  parameter int STRETCH = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req_valid,
  input  logic [1:0]               req_addr,
  output logic                     req_ready,
  input  logic                     stall,
  input  logic                     scan_start,
  output logic                     address0,
  output logic                     address1,
  output logic                     enable,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   count
`ifdef SEQ_OVERFLOW_FLAG_EN
  ,
  output logic                     overflow
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int SW = $clog2(STRETCH + 1);
  typedef enum logic [1:0] {IDLE, ISSUE, SCAN} state_t;
  state_t          state_q, state_d;
  logic [1:0]      mem_q [DEPTH];
  logic [AW-1:0]   wr_q, rd_q;
  logic [AW:0]     cnt_q;
  logic            pend_q;
  logic [SW-1:0]   st_q, st_d;
  logic [1:0]      idx_q, idx_d, sel_q, sel_d;
  logic            en_q, en_d;
  logic            push, pop, take_scan, full;
  assign full      = cnt_q == (AW+1)'(DEPTH);
  assign req_ready = !reset && !full;
  assign push      = req_valid && req_ready;
  assign address0  = sel_q[0];
  assign address1  = sel_q[1];
  assign enable    = en_q;
  assign count     = cnt_q;
  assign busy      = state_q != IDLE || pend_q || cnt_q != '0;
  // slot scheduler: hold while stretching, step the sweep, else pick scan > FIFO > idle
  always_comb begin
    state_d   = state_q;
    st_d      = st_q;
    idx_d     = idx_q;
    sel_d     = sel_q;
    en_d      = en_q;
    pop       = 1'b0;
    take_scan = 1'b0;
    if (!stall) begin
      if (state_q != IDLE && st_q != '0) begin
        st_d = st_q - SW'(1);
      end else if (state_q == SCAN && idx_q != 2'd3) begin
        idx_d = idx_q + 2'd1;
        sel_d = idx_q + 2'd1;
        st_d  = SW'(STRETCH - 1);
      end else if (pend_q) begin
        state_d   = SCAN;
        idx_d     = 2'd0;
        sel_d     = 2'd0;
        en_d      = 1'b1;
        st_d      = SW'(STRETCH - 1);
        take_scan = 1'b1;
      end else if (cnt_q != '0) begin
        state_d = ISSUE;
        sel_d   = mem_q[rd_q];
        en_d    = 1'b1;
        st_d    = SW'(STRETCH - 1);
        pop     = 1'b1;
      end else begin
        state_d = IDLE;
        sel_d   = 2'd0;
        en_d    = 1'b0;
        st_d    = '0;
      end
    end
  end
  // FIFO storage; contents are only read while occupancy is non-zero
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= req_addr;
  end
  // control, pointer and registered decoder-facing state
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      st_q    <= '0;
      idx_q   <= '0;
      sel_q   <= '0;
      en_q    <= 1'b0;
      pend_q  <= 1'b0;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      st_q    <= st_d;
      idx_q   <= idx_d;
      sel_q   <= sel_d;
      en_q    <= en_d;
      pend_q  <= scan_start || (pend_q && !take_scan);
      wr_q    <= wr_q + AW'(push);
      rd_q    <= rd_q + AW'(pop);
      cnt_q   <= cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
`ifdef SEQ_OVERFLOW_FLAG_EN
  logic ovf_q;
  assign overflow = ovf_q;
  // sticky flag for any request presented while the FIFO is full
  always_ff @(posedge clk) begin
    if (reset) ovf_q <= 1'b0;
    else if (req_valid && full) ovf_q <= 1'b1;
  end
`endif
endmodule

// File: doc/decoder_addr_sequencer.md
Name: decoder_addr_sequencer

Overview:
Sequencer that drives the address0/address1/enable inputs of the 2-to-4 enable decoder.
- Buffers 2-bit select requests from upstream in a small FIFO (valid/ready).
- Issues one select per slot with enable asserted for a programmable number of cycles.
- Provides a scan mode that sweeps selects 0..3.
- All decoder-facing outputs are registered, so the decoder sees glitch-free inputs.

Parameters:
DEPTH, 4, FIFO entries; power of two, at least 2.
STRETCH, 1, cycles enable stays high per issued select; at least 1.

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
req_valid  input  1  upstream request valid
req_addr  input  2  requested select; bit0 maps to address0, bit1 to address1
req_ready  output  1  FIFO can accept; equals !full && !reset
stall  input  1  downstream hold; freezes issue logic
scan_start  input  1  single-cycle pulse requesting a 0..3 sweep
address0  output  1  to decoder address0
address1  output  1  to decoder address1
enable  output  1  to decoder enable
busy  output  1  high in ISSUE or SCAN, or while scan_pending or the FIFO is non-empty
count  output  clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Clocking: single clock clk. Reset is synchronous and active-high on reset.
- Reset:
  - state=IDLE; FIFO empty; count=0; scan_pending=0.
  - address0=address1=enable=busy=0; req_ready=0 while reset is high.
  - Reset mid-ISSUE or mid-SCAN aborts immediately and discards all FIFO contents.
- Push: occurs on an edge with req_valid && req_ready. req_valid while full is ignored; no overwrite.
- Push plus pop in the same edge: count is unchanged.
- scan_start in any state sets scan_pending on that edge. Repeated pulses while pending coalesce into one sweep.
- States: IDLE, ISSUE, SCAN. The stretch counter st counts down from STRETCH-1.
- IDLE (enable=0), evaluated on an edge with stall=0, in priority order:
  - scan_pending: go to SCAN, idx=0, drive select 0, enable=1, clear scan_pending.
  - else FIFO non-empty: pop head, go to ISSUE, drive head select, enable=1.
  - else stay in IDLE.
- ISSUE: hold select and enable=1. When st reaches 0, the next slot is chosen in the same IDLE priority order with no bubble:
  - scan_pending: go to SCAN.
  - else FIFO non-empty: pop head and restart ISSUE.
  - else go to IDLE with enable=0.
- SCAN: selects 0,1,2,3, each held STRETCH cycles with enable=1. After idx 3 completes, the next slot is chosen as in ISSUE.
- stall=1:
  - state, st, idx and all outputs are frozen; no pop.
  - Pushes and scan_start latching continue.
  - stall is ignored during reset.
- Latency: request accepted at edge k into an empty FIFO in IDLE, stall=0 → count=1 after edge k, enable=1 with the select after edge k+1.
- Back-to-back entries with STRETCH=1 produce enable high on consecutive cycles with a changing select.
- enable never rises without valid select bits in the same cycle. No X on outputs after reset.

Optional Feature:
Macro SEQ_OVERFLOW_FLAG_EN.
- Defined: adds port overflow (output, 1).
  - Set on any edge where req_valid=1 and the FIFO is full; sticky.
  - Cleared only by reset; reset value 0.
- Undefined: no port and no logic; rejected requests are silently dropped via req_ready.

Test Plan:
1. Reset, then push req_addr=2 at edge 0 → after edge 1: address1=1, address0=0, enable=1 for exactly 1 cycle; then enable=0, busy=0, count=0.
2. stall=1, push 3,0,1,2,3 on consecutive cycles:
   - count=4 and req_ready=0 after the 4th push; the 5th is rejected (overflow=1 if SEQ_OVERFLOW_FLAG_EN).
   - Drop stall → enable=1 for 4 consecutive cycles with selects 3,0,1,2, no bubble.
3. scan_start pulse in IDLE → selects 0,1,2,3 on consecutive cycles with enable=1, then enable=0.
4. FIFO holds {1,2}, scan_start during ISSUE of 1 → output order 1, 0,1,2,3 (scan), 2.
5. STRETCH=3, push 3, assert stall for 1 cycle mid-hold → select 3 with enable high for 4 cycles total.
6. Assert reset during SCAN idx=2 with count=2 → after that edge all outputs 0, count=0, req_ready=0; after release, req_ready=1.
